// File: rtl/conv_layer_input_row_buffer.sv
// ---------------------------------------------------------------------------
// conv_layer_input_row_buffer
//
// Line buffer between the external pixel memory and the conv-kernel input
// interface. It holds BUFFER_ROW image rows of BUFFER_COL words each.
// While the interface is in LOAD, one pixel per cycle is written into the
// column given by col_index. That column scrolls up by one row, so the
// oldest word in it is dropped. In every other state the contents hold.
// Any whole row can be read as a flat bus. Column 0 sits in the most
// significant word.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset, clears every word
//   data_in        in   pixel word from external memory (DATA_WIDTH)
//   col_index      in   column written during LOAD (BUFFER_COL_WIDTH)
//   row_index      in   row presented on data_out_bus (BUFFER_ROW_WIDTH)
//   preload_cycle  in   reserved, ignored (BUFFER_ROW_WIDTH)
//   current_state  in   interface state: IDLE=0 SHIFT=1 BIAS=2 LOAD=3
//   data_out_bus   out  selected row, BUFFER_COL*DATA_WIDTH bits
//
// Build option
//   INBUF_OUT_REG_EN : when defined, data_out_bus is registered, which
//                      gives a read latency of one cycle. When undefined,
//                      the read path is purely combinational.
// ---------------------------------------------------------------------------
module conv_layer_input_row_buffer #(
   parameter int DATA_WIDTH       = 32,
   parameter int BUFFER_ROW       = 2,
   parameter int BUFFER_ROW_WIDTH = 2,
   parameter int BUFFER_COL       = 8,
   parameter int BUFFER_COL_WIDTH = 3
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [DATA_WIDTH-1:0]            data_in,
   input  logic [BUFFER_COL_WIDTH-1:0]      col_index,
   input  logic [BUFFER_ROW_WIDTH-1:0]      row_index,
   input  logic [BUFFER_ROW_WIDTH-1:0]      preload_cycle,
   input  logic [2:0]                       current_state,
   output logic [BUFFER_COL*DATA_WIDTH-1:0] data_out_bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SHIFT = 3'd1,
      ST_BIAS  = 3'd2,
      ST_LOAD  = 3'd3
   } if_state_t;

   logic [DATA_WIDTH-1:0]            mem [BUFFER_ROW][BUFFER_COL];
   logic                             load_en;
   logic [BUFFER_COL*DATA_WIDTH-1:0] row_bus;
   logic                             unused_preload;

   // preload_cycle is part of the interface but carries no meaning here.
   assign unused_preload = ^preload_cycle;

   // A write happens only in LOAD and only for a column that exists.
   // An out-of-range col_index in LOAD leaves every word untouched.
   assign load_en = (current_state == ST_LOAD) &&
                    (32'(col_index) < BUFFER_COL);

   // Storage. Row 0 is the oldest row. A load shifts the addressed column
   // up by one row and places data_in in the bottom row. The columns are
   // decoded by comparison, which keeps every index at its natural width.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < BUFFER_ROW; r++) begin
            for (int c = 0; c < BUFFER_COL; c++) begin
               mem[r][c] <= '0;
            end
         end
      end else if (load_en) begin
         for (int c = 0; c < BUFFER_COL; c++) begin
            if (32'(col_index) == c) begin
               for (int r = 0; r < BUFFER_ROW - 1; r++) begin
                  mem[r][c] <= mem[r+1][c];
               end
               mem[BUFFER_ROW-1][c] <= data_in;
            end
         end
      end
   end

   // Row select. This path is combinational, so a read in the same cycle
   // as a write to the same word returns the value from before the edge.
   // A row_index beyond the last row drives zeros.
   always_comb begin
      row_bus = '0;
      for (int r = 0; r < BUFFER_ROW; r++) begin
         if (32'(row_index) == r) begin
            for (int c = 0; c < BUFFER_COL; c++) begin
               row_bus[(BUFFER_COL-c)*DATA_WIDTH-1 -: DATA_WIDTH] = mem[r][c];
            end
         end
      end
   end

`ifdef INBUF_OUT_REG_EN
   logic [BUFFER_COL*DATA_WIDTH-1:0] out_reg;

   // The output register reloads on every edge. The reset clears it
   // together with the storage, so the bus reads zero straight away.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_reg <= '0;
      end else begin
         out_reg <= row_bus;
      end
   end

   assign data_out_bus = out_reg;
`else
   assign data_out_bus = row_bus;
`endif

endmodule

// File: tb/tb_conv_layer_input_row_buffer.sv
// ---------------------------------------------------------------------------
// tb_conv_layer_input_row_buffer
//
// Self-checking bench for conv_layer_input_row_buffer. The reference model
// keeps one FIFO per column. A load pushes the new word to the back and
// drops the oldest one, so row r of column c is simply colq[c][r].
// ---------------------------------------------------------------------------
module tb_conv_layer_input_row_buffer;

   localparam int DW  = 32;
   localparam int BR  = 2;
   localparam int BRW = 2;
   localparam int BC  = 8;
   localparam int BCW = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [DW-1:0]     data_in;
   logic [BCW-1:0]    col_index;
   logic [BRW-1:0]    row_index;
   logic [BRW-1:0]    preload_cycle;
   logic [2:0]        current_state;
   logic [BC*DW-1:0]  data_out_bus;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] colq [BC][$];

   conv_layer_input_row_buffer #(
      .DATA_WIDTH(DW), .BUFFER_ROW(BR), .BUFFER_ROW_WIDTH(BRW),
      .BUFFER_COL(BC), .BUFFER_COL_WIDTH(BCW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .data_in(data_in),
      .col_index(col_index),
      .row_index(row_index),
      .preload_cycle(preload_cycle),
      .current_state(current_state),
      .data_out_bus(data_out_bus)
   );

   always #5 clk = ~clk;

   // Reference model: every column starts out holding BR zero words.
   task automatic modelReset();
      for (int c = 0; c < BC; c++) begin
         colq[c].delete();
         for (int r = 0; r < BR; r++) colq[c].push_back('0);
      end
   endtask

   task automatic modelEdge(input logic [2:0] st, input int col, input logic [DW-1:0] d);
      if (st == 3'd3 && col < BC) begin
         colq[col].push_back(d);
         void'(colq[col].pop_front());
      end
   endtask

   function automatic logic [BC*DW-1:0] expectedRow(input int r);
      logic [BC*DW-1:0] b;
      b = '0;
      if (r < BR) begin
         for (int c = 0; c < BC; c++) b[(BC-c)*DW-1 -: DW] = colq[c][r];
      end
      return b;
   endfunction

   // Inputs change on the falling edge, well away from the active edge.
   task automatic applyStimulus(input logic [2:0] st, input int col,
                                input logic [DW-1:0] d, input int row);
      @(negedge clk);
      current_state = st;
      col_index     = col[BCW-1:0];
      data_in       = d;
      row_index     = row[BRW-1:0];
      preload_cycle = BRW'($urandom_range(0, 3));
   endtask

   task automatic checkOutput(input string tag, input logic [BC*DW-1:0] exp);
      checks++;
      assert (data_out_bus === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, data_out_bus, exp);
      end
   endtask

   task automatic checkWord(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic doLoad(input int col, input logic [DW-1:0] d);
      applyStimulus(3'd3, col, d, 0);
      @(posedge clk);
      modelEdge(3'd3, col, d);
      #1;
   endtask

   // Reads one row while the buffer is idle. In the registered build the
   // value becomes visible one edge after row_index changes.
   task automatic readRow(input string tag, input int row);
      applyStimulus(3'd0, 0, '0, row);
`ifdef INBUF_OUT_REG_EN
      @(posedge clk);
      #1;
`else
      #1;
`endif
      checkOutput(tag, expectedRow(row));
   endtask

   initial begin
      logic [2:0]       st;
      int               col;
      int               row;
      logic [DW-1:0]    d;
      logic [BC*DW-1:0] exp;
      logic [2:0]       hold_states [4];

      hold_states[0] = 3'd0;
      hold_states[1] = 3'd1;
      hold_states[2] = 3'd2;
      hold_states[3] = 3'd5;

      // Power-on reset: every row reads as zero.
      rst_n = 1'b0; data_in = '0; col_index = '0; row_index = '0;
      preload_cycle = '0; current_state = 3'd0;
      modelReset();
      for (int r = 0; r < 4; r++) begin
         row_index = r[BRW-1:0];
         #1;
         checkOutput("reset_row", '0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Two full sweeps: row 0 gets the first sweep, row 1 the second.
      $display("[TB] full sweeps");
      for (int c = 0; c < BC; c++) doLoad(c, 32'h3F80_0000 + c);
      for (int c = 0; c < BC; c++) doLoad(c, 32'h4000_0000 + c);
      readRow("sweep_row0", 0);
      checkWord("row0_ms", data_out_bus[BC*DW-1 -: DW], 32'h3F80_0000);
      readRow("sweep_row1", 1);
      checkWord("row1_ms", data_out_bus[BC*DW-1 -: DW], 32'h4000_0000);
      checkWord("row1_ls", data_out_bus[DW-1:0], 32'h4000_0007);

      // Non-LOAD states with toggling inputs must not disturb the contents.
      $display("[TB] hold states");
      for (int i = 0; i < 20; i++) begin
         st = hold_states[$urandom_range(0, 3)];
         col = $urandom_range(0, BC - 1);
         d = $urandom;
         applyStimulus(st, col, d, 0);
         @(posedge clk);
         modelEdge(st, col, d);
      end
      for (int r = 0; r < 4; r++) readRow("hold_row", r);

      // A partial sweep scrolls only the columns it touches.
      $display("[TB] partial sweep");
      for (int c = 0; c < 4; c++) doLoad(c, $urandom);
      readRow("partial_row0", 0);
      readRow("partial_row1", 1);

      // Random traffic: half the cycles load, and any row is read.
      $display("[TB] random traffic");
      for (int i = 0; i < 300; i++) begin
         st  = ($urandom_range(0, 1) == 1) ? 3'd3 : 3'($urandom_range(0, 7));
         col = $urandom_range(0, BC - 1);
         d   = $urandom;
         row = $urandom_range(0, 3);
         applyStimulus(st, col, d, row);
         exp = expectedRow(row);
`ifndef INBUF_OUT_REG_EN
         #1;
         checkOutput("rand_comb", exp);
`endif
         @(posedge clk);
         modelEdge(st, col, d);
         #1;
`ifdef INBUF_OUT_REG_EN
         checkOutput("rand_reg", exp);
`endif
      end

      // Reset asserted in the middle of a LOAD clears the bus with no clock edge.
      $display("[TB] mid-load reset");
      applyStimulus(3'd3, 2, 32'h1234_5678, 1);
      #2;
      rst_n = 1'b0;
      modelReset();
      for (int r = 0; r < 4; r++) begin
         row_index = r[BRW-1:0];
         #1;
         checkOutput("midload_reset_row", '0);
      end
      applyStimulus(3'd0, 0, '0, 0);
      rst_n = 1'b1;
      doLoad(5, 32'hDEAD_BEEF);
      readRow("after_reset_row1", 1);
      readRow("after_reset_row0", 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
